// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared register-file constants, write-back request type and scoreboard mask helper.
package regfile_wb_arbiter_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef logic [REG_AW-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xdata_t;

    typedef struct packed {
        reg_addr_t addr;
        xdata_t    data;
    } wb_req_t;

    // One-hot scoreboard mask; x0 never maps to a busy bit.
    function automatic logic [NREG-1:0] reg_onehot(input reg_addr_t a);
        logic [NREG-1:0] v;
        v    = '0;
        v[a] = 1'b1;
        v[REG_ZERO] = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_starve_ctr.sv
// Purpose: counts consecutive denied cycles of the execute port and raises its priority.
// Latency: promote asserts the cycle after the STARVE_LIMIT-th denial, drops after an A grant.
// Backpressure: none; pure observer of a_wait / a_grant.
module wb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic a_wait,
    input  logic a_grant,
    output logic promote
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          promote_q, promote_d;

    always_comb begin
        cnt_d     = cnt_q;
        promote_d = promote_q;
        if (a_grant) begin
            cnt_d     = '0;
            promote_d = 1'b0;
        end else if (a_wait) begin
            // Saturate so a long stall cannot wrap back below the limit.
            if (cnt_q != LIM) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (cnt_q >= LIM - 1'b1) begin
                promote_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q     <= '0;
            promote_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            promote_q <= promote_d;
        end
    end

    assign promote = promote_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: arbitrates execute (A) and load (B) results onto the single regfile write port; keeps the pending-write scoreboard.
// Latency: 1 cycle from grant to o_waddr/o_wdata; busy bit clears on the edge that writes the register.
// Backpressure: valid/ready per producer, B favoured unless A has starved; reservations stall on a busy destination.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rsv_valid,
    input  logic [4:0]  i_rsv_addr,
    output logic        o_rsv_ready,
    input  logic        i_a_valid,
    input  logic [4:0]  i_a_addr,
    input  logic [31:0] i_a_data,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_addr,
    input  logic [31:0] i_b_data,
    output logic        o_b_ready,
    output logic [4:0]  o_waddr,
    output logic [31:0] o_wdata,
    output logic [31:0] o_busy
);

    wb_req_t         wb_q, wb_d;
    logic [NREG-1:0] busy_q, busy_d;
    logic            promote;
    logic            rsv_rdy, a_rdy, b_rdy;
    logic            a_grant, b_grant, a_wait;

    // Readies depend only on the other side's valid, so a producer may wait on ready.
    always_comb begin
        rsv_rdy = ~i_rst & ~busy_q[i_rsv_addr];
        a_rdy   = 1'b0;
        b_rdy   = 1'b0;
        if (!i_rst) begin
            if (promote) begin
                a_rdy = 1'b1;
                b_rdy = ~i_a_valid;
            end else begin
                b_rdy = 1'b1;
                a_rdy = ~i_b_valid;
            end
        end
    end

    assign a_grant = i_a_valid & a_rdy;
    assign b_grant = i_b_valid & b_rdy;
    assign a_wait  = i_a_valid & ~a_rdy;

    wb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .a_wait  (a_wait),
        .a_grant (a_grant),
        .promote (promote)
    );

    always_comb begin
        wb_d = '0;
        if (b_grant) begin
            wb_d.addr = i_b_addr;
            wb_d.data = i_b_data;
        end else if (a_grant) begin
            wb_d.addr = i_a_addr;
            wb_d.data = i_a_data;
        end
    end

    // Clear the register being written this cycle; a reservation can never hit it because it is still busy.
    always_comb begin
        busy_d = busy_q & ~reg_onehot(wb_q.addr);
        if (i_rsv_valid && rsv_rdy) begin
            busy_d = busy_d | reg_onehot(i_rsv_addr);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wb_q   <= '0;
            busy_q <= '0;
        end else begin
            wb_q   <= wb_d;
            busy_q <= busy_d;
        end
    end

    assign o_rsv_ready = rsv_rdy;
    assign o_a_ready   = a_rdy;
    assign o_b_ready   = b_rdy;
    assign o_waddr     = wb_q.addr;
    assign o_wdata     = wb_q.data;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_rsv_valid;
    logic [4:0]  i_rsv_addr;
    logic        o_rsv_ready;
    logic        i_a_valid;
    logic [4:0]  i_a_addr;
    logic [31:0] i_a_data;
    logic        o_a_ready;
    logic        i_b_valid;
    logic [4:0]  i_b_addr;
    logic [31:0] i_b_data;
    logic        o_b_ready;
    logic [4:0]  o_waddr;
    logic [31:0] o_wdata;
    logic [31:0] o_busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_rsv_valid (i_rsv_valid),
        .i_rsv_addr  (i_rsv_addr),
        .o_rsv_ready (o_rsv_ready),
        .i_a_valid   (i_a_valid),
        .i_a_addr    (i_a_addr),
        .i_a_data    (i_a_data),
        .o_a_ready   (o_a_ready),
        .i_b_valid   (i_b_valid),
        .i_b_addr    (i_b_addr),
        .i_b_data    (i_b_data),
        .o_b_ready   (o_b_ready),
        .o_waddr     (o_waddr),
        .o_wdata     (o_wdata),
        .o_busy      (o_busy)
    );

    task automatic drive_idle();
        i_rsv_valid = 1'b0; i_rsv_addr = 5'd0;
        i_a_valid = 1'b0; i_a_addr = 5'd0; i_a_data = 32'd0;
        i_b_valid = 1'b0; i_b_addr = 5'd0; i_b_data = 32'd0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_rsv_valid = 1'b1; i_rsv_addr = 5'd3;
        i_a_valid = 1'b1; i_a_addr = 5'd6; i_a_data = 32'h1234_5678;
        i_b_valid = 1'b1; i_b_addr = 5'd9; i_b_data = 32'h8765_4321;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_chk++; if (o_waddr !== 5'd0) $display("FAIL reset_waddr got %0h exp 0", o_waddr); else n_pass++;
        n_chk++; if (o_wdata !== 32'd0) $display("FAIL reset_wdata got %0h exp 0", o_wdata); else n_pass++;
        n_chk++; if (o_busy !== 32'd0) $display("FAIL reset_busy got %0h exp 0", o_busy); else n_pass++;
        n_chk++; if ({o_rsv_ready, o_a_ready, o_b_ready} !== 3'b000)
            $display("FAIL reset_readies got %b exp 000", {o_rsv_ready, o_a_ready, o_b_ready}); else n_pass++;
        i_rst = 1'b0;
        drive_idle();
        for (int i = 0; i < 4; i++) begin
            i_rsv_addr = 5'(i * 9);
            #1;
            n_chk++; if (o_rsv_ready !== 1'b1) $display("FAIL post_reset_rsv_ready addr %0d got %b exp 1", i_rsv_addr, o_rsv_ready); else n_pass++;
        end
    endtask

    task automatic test_reserve_write();
        @(negedge clk); drive_idle(); i_rsv_valid = 1'b1; i_rsv_addr = 5'd5; #1;
        n_chk++; if (o_rsv_ready !== 1'b1) $display("FAIL rw_rsv_ready got %b exp 1", o_rsv_ready); else n_pass++;
        @(negedge clk); i_rsv_valid = 1'b0; #1;
        n_chk++; if (o_busy[5] !== 1'b1) $display("FAIL rw_busy_set got %b exp 1", o_busy[5]); else n_pass++;
        @(negedge clk); i_rsv_valid = 1'b1; i_rsv_addr = 5'd5; #1;
        n_chk++; if (o_rsv_ready !== 1'b0) $display("FAIL rw_waw_stall got %b exp 0", o_rsv_ready); else n_pass++;
        @(negedge clk); i_rsv_valid = 1'b0;
        i_a_valid = 1'b1; i_a_addr = 5'd5; i_a_data = 32'hDEAD_BEEF; #1;
        n_chk++; if (o_a_ready !== 1'b1) $display("FAIL rw_a_ready got %b exp 1", o_a_ready); else n_pass++;
        @(negedge clk); i_a_valid = 1'b0; #1;
        n_chk++; if (o_waddr !== 5'd5) $display("FAIL rw_waddr got %0d exp 5", o_waddr); else n_pass++;
        n_chk++; if (o_wdata !== 32'hDEAD_BEEF) $display("FAIL rw_wdata got %h exp deadbeef", o_wdata); else n_pass++;
        n_chk++; if (o_busy[5] !== 1'b1) $display("FAIL rw_busy_during_write got %b exp 1", o_busy[5]); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (o_busy !== 32'd0) $display("FAIL rw_busy_cleared got %h exp 0", o_busy); else n_pass++;
        n_chk++; if (o_waddr !== 5'd0 || o_wdata !== 32'd0) $display("FAIL rw_idle_out got %0d/%h exp 0/0", o_waddr, o_wdata); else n_pass++;
    endtask

    task automatic test_contention();
        @(negedge clk); drive_idle();
        i_a_valid = 1'b1; i_a_addr = 5'd3; i_a_data = 32'h1;
        i_b_valid = 1'b1; i_b_addr = 5'd4; i_b_data = 32'h2; #1;
        n_chk++; if ({o_a_ready, o_b_ready} !== 2'b01) $display("FAIL cont_readies got %b exp 01", {o_a_ready, o_b_ready}); else n_pass++;
        @(negedge clk); i_b_valid = 1'b0; #1;
        n_chk++; if (o_waddr !== 5'd4 || o_wdata !== 32'h2) $display("FAIL cont_b_first got %0d/%h exp 4/2", o_waddr, o_wdata); else n_pass++;
        n_chk++; if (o_a_ready !== 1'b1) $display("FAIL cont_a_retry_ready got %b exp 1", o_a_ready); else n_pass++;
        @(negedge clk); i_a_valid = 1'b0; #1;
        n_chk++; if (o_waddr !== 5'd3 || o_wdata !== 32'h1) $display("FAIL cont_a_second got %0d/%h exp 3/1", o_waddr, o_wdata); else n_pass++;
    endtask

    task automatic test_starvation();
        logic [4:0]  prev_b;
        logic [31:0] prev_bd;
        prev_b = 5'd0; prev_bd = 32'd0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); drive_idle();
            i_a_valid = 1'b1; i_a_addr = 5'd9; i_a_data = 32'h0000_900D;
            i_b_valid = 1'b1; i_b_addr = 5'($urandom_range(10, 20)); i_b_data = $urandom; #1;
            if (c < 4) begin
                n_chk++; if ({o_a_ready, o_b_ready} !== 2'b01) $display("FAIL starve_denied c%0d got %b exp 01", c, {o_a_ready, o_b_ready}); else n_pass++;
            end else begin
                n_chk++; if ({o_a_ready, o_b_ready} !== 2'b10) $display("FAIL starve_promoted got %b exp 10", {o_a_ready, o_b_ready}); else n_pass++;
            end
            if (c > 0) begin
                n_chk++; if (o_waddr !== prev_b || o_wdata !== prev_bd) $display("FAIL starve_b_write c%0d got %0d/%h exp %0d/%h", c, o_waddr, o_wdata, prev_b, prev_bd); else n_pass++;
            end
            if (c < 4) begin prev_b = i_b_addr; prev_bd = i_b_data; end
        end
        @(negedge clk); i_a_valid = 1'b0; i_b_addr = 5'd12; i_b_data = 32'hB0B0_0012; #1;
        n_chk++; if (o_waddr !== 5'd9 || o_wdata !== 32'h0000_900D) $display("FAIL starve_a_write got %0d/%h exp 9/900d", o_waddr, o_wdata); else n_pass++;
        n_chk++; if (o_b_ready !== 1'b1) $display("FAIL starve_b_ready_after got %b exp 1", o_b_ready); else n_pass++;
        @(negedge clk); i_a_valid = 1'b1; i_b_addr = 5'd13; #1;
        n_chk++; if (o_waddr !== 5'd12 || o_wdata !== 32'hB0B0_0012) $display("FAIL starve_b_next got %0d/%h exp 12/b0b00012", o_waddr, o_wdata); else n_pass++;
        n_chk++; if (o_a_ready !== 1'b0) $display("FAIL starve_b_prio_restored got %b exp 0", o_a_ready); else n_pass++;
        @(negedge clk); i_b_valid = 1'b0;
        @(negedge clk); drive_idle();
    endtask

    task automatic test_x0();
        @(negedge clk); drive_idle(); i_rsv_valid = 1'b1; i_rsv_addr = 5'd0; #1;
        n_chk++; if (o_rsv_ready !== 1'b1) $display("FAIL x0_rsv_ready got %b exp 1", o_rsv_ready); else n_pass++;
        @(negedge clk); i_rsv_valid = 1'b0;
        i_b_valid = 1'b1; i_b_addr = 5'd0; i_b_data = 32'hFFFF_FFFF; #1;
        n_chk++; if (o_busy !== 32'd0) $display("FAIL x0_rsv_no_busy got %h exp 0", o_busy); else n_pass++;
        n_chk++; if (o_b_ready !== 1'b1) $display("FAIL x0_b_ready got %b exp 1", o_b_ready); else n_pass++;
        @(negedge clk); i_b_valid = 1'b0; #1;
        n_chk++; if (o_waddr !== 5'd0 || o_wdata !== 32'hFFFF_FFFF) $display("FAIL x0_write got %0d/%h exp 0/ffffffff", o_waddr, o_wdata); else n_pass++;
        n_chk++; if (o_busy !== 32'd0) $display("FAIL x0_busy got %h exp 0", o_busy); else n_pass++;
    endtask

    task automatic test_mid_reset();
        @(negedge clk); drive_idle(); i_rsv_valid = 1'b1; i_rsv_addr = 5'd7;
        @(negedge clk); i_rsv_valid = 1'b0;
        i_a_valid = 1'b1; i_a_addr = 5'd7; i_a_data = 32'h77; #1;
        n_chk++; if (o_busy[7] !== 1'b1 || o_a_ready !== 1'b1) $display("FAIL mr_pre got busy7=%b a_rdy=%b exp 1/1", o_busy[7], o_a_ready); else n_pass++;
        @(negedge clk); i_rst = 1'b1; i_a_addr = 5'd8; i_a_data = 32'h88; #1;
        n_chk++; if (o_waddr !== 5'd7 || o_a_ready !== 1'b0) $display("FAIL mr_in_reset got waddr=%0d a_rdy=%b exp 7/0", o_waddr, o_a_ready); else n_pass++;
        @(negedge clk); i_rst = 1'b0; i_a_valid = 1'b0; #1;
        n_chk++; if (o_busy !== 32'd0 || o_waddr !== 5'd0 || o_wdata !== 32'd0)
            $display("FAIL mr_after got busy=%h waddr=%0d wdata=%h exp 0/0/0", o_busy, o_waddr, o_wdata); else n_pass++;
        // Starve A three times, reset, then A must need a full four denials again.
        i_a_valid = 1'b1; i_a_addr = 5'd1; i_a_data = 32'h11;
        i_b_valid = 1'b1; i_b_addr = 5'd2; i_b_data = 32'h22;
        repeat (3) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk); i_rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_chk++; if (o_a_ready !== (c == 4)) $display("FAIL mr_ctr_cleared c%0d got %b exp %b", c, o_a_ready, (c == 4)); else n_pass++;
            @(negedge clk);
        end
        drive_idle();
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] m_busy;
        logic [4:0]  m_waddr;
        logic [31:0] m_wdata;
        int          m_denied;
        bit          m_promote;
        bit          ea, eb, er, ga, gb;
        @(negedge clk); drive_idle(); i_rst = 1'b1;
        @(negedge clk); i_rst = 1'b0;
        m_busy = 32'd0; m_waddr = 5'd0; m_wdata = 32'd0; m_denied = 0; m_promote = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_rsv_valid = 1'($urandom_range(0, 1));
            i_rsv_addr  = 5'($urandom_range(0, 7));
            i_a_valid   = ($urandom_range(0, 2) != 0);
            i_a_addr    = 5'($urandom_range(0, 7));
            i_a_data    = $urandom;
            i_b_valid   = ($urandom_range(0, 3) != 0);
            i_b_addr    = 5'($urandom_range(0, 7));
            i_b_data    = $urandom;
            #1;
            eb = m_promote ? !i_a_valid : 1'b1;
            ea = m_promote ? 1'b1 : !i_b_valid;
            er = !m_busy[i_rsv_addr];
            n_chk++; if ({o_rsv_ready, o_a_ready, o_b_ready} !== {er, ea, eb})
                $display("FAIL rnd_readies cyc%0d got %b exp %b", cyc, {o_rsv_ready, o_a_ready, o_b_ready}, {er, ea, eb}); else n_pass++;
            n_chk++; if (o_waddr !== m_waddr || o_wdata !== m_wdata)
                $display("FAIL rnd_write cyc%0d got %0d/%h exp %0d/%h", cyc, o_waddr, o_wdata, m_waddr, m_wdata); else n_pass++;
            n_chk++; if (o_busy !== m_busy) $display("FAIL rnd_busy cyc%0d got %h exp %h", cyc, o_busy, m_busy); else n_pass++;
            ga = i_a_valid && ea;
            gb = i_b_valid && eb;
            if (m_waddr != 5'd0) m_busy[m_waddr] = 1'b0;
            if (i_rsv_valid && er && i_rsv_addr != 5'd0) m_busy[i_rsv_addr] = 1'b1;
            if (gb)      begin m_waddr = i_b_addr; m_wdata = i_b_data; end
            else if (ga) begin m_waddr = i_a_addr; m_wdata = i_a_data; end
            else         begin m_waddr = 5'd0;     m_wdata = 32'd0;    end
            if (ga) begin
                m_denied = 0; m_promote = 1'b0;
            end else if (i_a_valid) begin
                m_denied++;
                if (m_denied >= 4) m_promote = 1'b1;
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        drive_idle();
        i_rst = 1'b1;
        test_reset();
        test_reserve_write();
        test_contention();
        test_starvation();
        test_x0();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
